// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame buffer geometry, VGA 640x480 timing and RGB565 field constants
package fb_pkg;

  // Frame buffer geometry
  localparam int FB_W        = 320;
  localparam int FB_H        = 240;
  localparam int FB_ADDR_W   = 17;
  localparam int FB_PIX_W    = 16;
  localparam int FB_ADDR_MAX = FB_W * FB_H - 1;

  // 640x480@60 timing in pixel clocks / lines
  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Counter width covers H_TOTAL=800 and V_TOTAL=525
  localparam int CNT_W = 10;

  // RGB565 fields: the top 4 bits of each channel drive the 4:4:4 pins
  localparam int RGB_W = 4;
  localparam int R_HI  = 15;
  localparam int G_HI  = 10;
  localparam int B_HI  = 4;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // Raw per-pixel control decoded from the counters
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } vga_ctl_t;

  // Doubled-pixel address (v/2)*320 + h/2, multiply by 320 as 256+64
  function automatic fb_addr_t fb_addr(input cnt_t h, input cnt_t v);
    fb_addr_t hh;
    fb_addr_t vh;
    hh = fb_addr_t'(h >> 1);
    vh = fb_addr_t'(v >> 1);
    return (vh << 8) + (vh << 6) + hh;
  endfunction

endpackage

// File: rtl/fb_vga_scanout_timing.sv
// rtl/fb_vga_scanout_timing.sv - pixel-enable divider, h/v counters and raw sync/active decode
module vga_timing
  import fb_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  output logic     pix_ce_o,
  output cnt_t     h_o,
  output cnt_t     v_o,
  output vga_ctl_t ctl_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  cnt_t             h_q, h_d;
  cnt_t             v_q, v_d;
  logic             pix_ce;

  // Strobe is decoded from the divider so it is low in reset (div=0, CLK_DIV>=2)
  assign pix_ce = (div_q == DIV_LAST);

  // Next-state: divider always runs, raster counters step on the strobe
  always_comb begin
    div_d = div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_ce) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Divider and raster position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pix_ce_o     = pix_ce;
  assign h_o          = h_q;
  assign v_o          = v_q;
  assign ctl_o.active = (h_q < H_ACT) && (v_q < V_ACT);
  assign ctl_o.hs_n   = !((h_q >= HS_START) && (h_q < HS_END));
  assign ctl_o.vs_n   = !((v_q >= VS_START) && (v_q < VS_END));

endmodule

// File: rtl/fb_vga_scanout.sv
// rtl/fb_vga_scanout.sv - VGA scan-out of the 320x240 RGB565 frame buffer with 2x doubling
module fb_vga_scanout
  import fb_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [FB_ADDR_W-1:0] read_addr,
  input  logic [FB_PIX_W-1:0]  read_data,
  output logic [RGB_W-1:0]     vga_r,
  output logic [RGB_W-1:0]     vga_g,
  output logic [RGB_W-1:0]     vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_de,
  output logic                 pix_ce,
  output logic                 frame_start
);

  cnt_t     h, v;
  vga_ctl_t ctl;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .pix_ce_o(pix_ce),
    .h_o     (h),
    .v_o     (v),
    .ctl_o   (ctl)
  );

  // Stage 1 state: read address plus control delayed to match the memory
  fb_addr_t read_addr_q;
  vga_ctl_t ctl1_q;
  logic     frame_start_q;

  // Stage 2 state: registered pins
  logic [RGB_W-1:0] r_q, g_q, b_q;
  logic             hsync_q, vsync_q, de_q;

  // Channel LSBs are dropped when reducing 565 to 444
  logic unused_pix_bits;
  assign unused_pix_bits = ^{read_data[11], read_data[6:5], read_data[0]};

  // Stage 1: issue the read, blanking reads address 0; pulse frame_start for one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_addr_q   <= '0;
      ctl1_q        <= '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (pix_ce) begin
        read_addr_q   <= ctl.active ? fb_addr(h, v) : '0;
        ctl1_q        <= ctl;
        frame_start_q <= (h == '0) && (v == '0);
      end
    end
  end

  // Stage 2: capture the returned pixel (already settled, CLK_DIV>=2) with aligned syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
    end else if (pix_ce) begin
      r_q     <= ctl1_q.active ? read_data[R_HI -: RGB_W] : '0;
      g_q     <= ctl1_q.active ? read_data[G_HI -: RGB_W] : '0;
      b_q     <= ctl1_q.active ? read_data[B_HI -: RGB_W] : '0;
      hsync_q <= ctl1_q.hs_n;
      vsync_q <= ctl1_q.vs_n;
      de_q    <= ctl1_q.active;
    end
  end

  assign read_addr   = read_addr_q;
  assign frame_start = frame_start_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// tb/tb_fb_vga_scanout.sv - directed bench for fb_vga_scanout on a reduced raster, CLK_DIV 4 and 2
module tb_fb_vga_scanout;

  // Reduced raster: 16+2+3+3 = 24 clocks/line, 6+1+2+1 = 10 lines/frame
  localparam int HT    = 24;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n      = 1'b0;
  logic const_mode = 1'b0;
  logic mon_en     = 1'b0;
  logic stat_en    = 1'b0;

  logic [16:0] ra  [2];
  logic [15:0] rd  [2];
  logic [3:0]  vr  [2];
  logic [3:0]  vg  [2];
  logic [3:0]  vb  [2];
  logic        hs  [2];
  logic        vs  [2];
  logic        de  [2];
  logic        pce [2];
  logic        fs  [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     [2];
  int fs_seen [2];
  int fs_at0  [2];
  int fs_at1  [2];
  int de_cnt = 0, hs_lo = 0, vs_lo = 0, fs_cnt = 0;

  fb_vga_scanout #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .read_addr(ra[0]), .read_data(rd[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]), .vga_hsync(hs[0]), .vga_vsync(vs[0]),
    .vga_de(de[0]), .pix_ce(pce[0]), .frame_start(fs[0])
  );

  fb_vga_scanout #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .read_addr(ra[1]), .read_data(rd[1]),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]), .vga_hsync(hs[1]), .vga_vsync(vs[1]),
    .vga_de(de[1]), .pix_ce(pce[1]), .frame_start(fs[1])
  );

  // Frame buffer model, one clk read latency: mem[a] = a[15:0], or all ones
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rd[i] <= const_mode ? 16'hFFFF : ra[i][15:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Expected read address for linear raster position q
  function automatic int exp_addr(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    return (h < 16 && v < 6) ? (v / 2) * 320 + h / 2 : 0;
  endfunction

  task automatic check_dut(input int i);
    int d, c, n, q, h, v, a, dat, er, eg, eb;
    bit act, ehs, evs, efs, epce;
    string p;
    d = div_of(i);
    c = cyc[i];
    p = $sformatf("div%0d clk%0d", d, c);
    a = 0; act = 0; ehs = 1; evs = 1; efs = 0; epce = 0; er = 0; eg = 0; eb = 0;
    if (rst_n) begin
      n    = c / d;
      epce = (c % d == d - 1);
      efs  = (c % d == 0) && (n >= 1) && (((n - 1) % FRAME) == 0);
      a    = (n >= 1) ? exp_addr(n - 1) : 0;
      if (n >= 2) begin
        q   = n - 2;
        h   = q % HT;
        v   = (q / HT) % VT;
        act = (h < 16) && (v < 6);
        ehs = !(h >= 18 && h < 21);
        evs = !(v >= 7 && v < 9);
        dat = const_mode ? 'hFFFF : (exp_addr(q) & 'hFFFF);
        if (act) begin
          er = (dat >> 12) & 15;
          eg = (dat >> 7) & 15;
          eb = (dat >> 1) & 15;
        end
      end
    end
    chk({p, " pix_ce"}, pce[i], epce);
    chk({p, " frame_start"}, fs[i], efs);
    chk({p, " read_addr"}, ra[i], a);
    chk({p, " hsync"}, hs[i], ehs);
    chk({p, " vsync"}, vs[i], evs);
    chk({p, " de"}, de[i], act);
    chk({p, " r"}, vr[i], er);
    chk({p, " g"}, vg[i], eg);
    chk({p, " b"}, vb[i], eb);
  endtask

  // Per-clk monitor: count edges since release, check both DUTs 1 time unit after the edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) cyc[i] = rst_n ? cyc[i] + 1 : 0;
    #1;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        check_dut(i);
        if (rst_n && fs[i]) begin
          if (fs_seen[i] == 0) fs_at0[i] = cyc[i];
          if (fs_seen[i] == 1) fs_at1[i] = cyc[i];
          fs_seen[i]++;
        end
      end
      if (stat_en) begin
        if (cyc[0] % 4 == 0 && cyc[0] / 4 >= 2 && cyc[0] / 4 <= FRAME + 1) begin
          de_cnt += int'(de[0]);
          hs_lo  += int'(!hs[0]);
          vs_lo  += int'(!vs[0]);
        end
        if (cyc[0] >= 1 && cyc[0] <= FRAME * 4 && fs[0]) fs_cnt++;
      end
    end
  end

  initial begin
    bit found;
    cyc     = '{0, 0};
    fs_seen = '{0, 0};
    fs_at0  = '{0, 0};
    fs_at1  = '{0, 0};
    mon_en  = 1'b1;

    // Reset held, then release; address-pattern frame buffer
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    stat_en = 1'b1;
    repeat (2 * FRAME * 4 + 40) @(negedge clk);
    stat_en = 1'b0;
    chk("de_pixels_per_frame", de_cnt, 96);
    chk("hsync_low_pixels_per_frame", hs_lo, 30);
    chk("vsync_low_pixels_per_frame", vs_lo, 48);
    chk("frame_start_pulses_per_frame", fs_cnt, 1);

    // Constant all-ones pixel data
    rst_n      = 1'b0;
    const_mode = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME * 4 + 40) @(negedge clk);

    // Mid-frame asynchronous reset at h=10, v=3 on the CLK_DIV=4 instance
    rst_n      = 1'b0;
    const_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(posedge clk);
      #2;
      if (cyc[0] == 329) found = 1;
    end
    chk("reach_h10_v3", found, 1);
    chk("addr_before_reset", ra[0], 324);
    chk("de_before_reset", de[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst read_addr", ra[0], 0);
    chk("async_rst de", de[0], 0);
    chk("async_rst hsync", hs[0], 1);
    chk("async_rst vsync", vs[0], 1);
    chk("async_rst r", vr[0], 0);
    chk("async_rst pix_ce", pce[0], 0);
    fs_seen = '{0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME * 4 + 40) @(negedge clk);
    chk("restart fs count div4", fs_seen[0], 2);
    chk("restart first fs div4", fs_at0[0], 4);
    chk("restart second fs div4", fs_at1[0], 964);
    chk("restart first fs div2", fs_at0[1], 2);
    chk("restart second fs div2", fs_at1[1], 482);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
